// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, FSM state codes and op-class helpers for iterative_mdu
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational bit of restoring division
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};

  // Top bit of diff is the borrow: set only when the divisor does not fit.
  always_comb begin
    if (!diff[XLEN]) begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iterative_mdu.sv
// rtl/iterative_mdu.sv - bit-serial RV M-extension multiply/divide unit
// Optional MDU_FAST_PATH_EN: special-case operands complete on the accept edge.
module iterative_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      op_q;
  logic [XLEN-1:0] acc_hi, acc_lo, opnd, special_val_q, result_q;
  logic            neg_q, special_q;

  logic            a_neg, b_neg, neg_d, div_zero, div_ovf, special_d, fast_go;
  logic [XLEN-1:0] a_mag, b_mag, special_val_d;

  // Accept-side decode: magnitudes, final sign and special-case results.
  always_comb begin
    a_neg    = a_signed(op) & a[XLEN-1];
    b_neg    = b_signed(op) & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    neg_d    = is_rem(op) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div(op) && (b == '0);
    div_ovf  = is_div(op) && a_signed(op) && (a == MOST_NEG) && (b == '1);
    special_d = div_zero | div_ovf;
    special_val_d = '0;
    if (div_zero)     special_val_d = is_rem(op) ? a : '1;
    else if (div_ovf) special_val_d = is_rem(op) ? '0 : a;
  end

`ifdef MDU_FAST_PATH_EN
  assign fast_go = special_d | (!is_div(op) && ((a == '0) || (b == '0)));
`else
  assign fast_go = 1'b0;
`endif

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   div_rem, div_quo, hi_nx, lo_nx, quo_fix, rem_fix, final_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (acc_hi),
    .quo_in  (acc_lo),
    .divisor (opnd),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  // acc_hi/acc_lo hold product-high/multiplier for MUL*, remainder/quotient for DIV*.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    if (is_div(op_q)) begin
      hi_nx = div_rem;
      lo_nx = div_quo;
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    prod     = {hi_nx, lo_nx};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_nx : lo_nx;
    rem_fix  = neg_q ? -hi_nx : hi_nx;
    if (special_q)            final_res = special_val_q;
    else if (is_rem(op_q))    final_res = rem_fix;
    else if (is_div(op_q))    final_res = quo_fix;
    else if (op_q == OP_MUL)  final_res = prod_fix[XLEN-1:0];
    else                      final_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      op_q          <= '0;
      acc_hi        <= '0;
      acc_lo        <= '0;
      opnd          <= '0;
      neg_q         <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      result_q      <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q          <= op;
            neg_q         <= neg_d;
            special_q     <= special_d;
            special_val_q <= special_val_d;
            acc_hi        <= '0;
            acc_lo        <= is_div(op) ? a_mag : b_mag;
            opnd          <= is_div(op) ? b_mag : a_mag;
            cnt           <= CNT_W'(XLEN - 1);
            if (fast_go) begin
              state    <= ST_DONE;
              result_q <= special_val_d;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          acc_hi <= hi_nx;
          acc_lo <= lo_nx;
          if (cnt == '0) begin
            state    <= ST_DONE;
            result_q <= final_res;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign result    = result_q;

endmodule
